// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter: shares one AXI4 slave port (S_AXI to the DDR controller)
// between two AXI4 masters (m0 = Rocket io_mem_axi, m1 = loader/DMA).
// AW and AR are arbitrated independently, one burst per grant. The outgoing
// ID is {grant_idx, master_id}; B and R are routed back on that top ID bit.
// Outstanding bursts per direction are capped at MAXOUT.
//
// Ports:
//   clock, reset_n      host_clk, synchronous active-low reset
//   m0_axi_*, m1_axi_*  slave-side AXI4 ports (AW, W, B, AR, R)
//   s_axi_*             master-side AXI4 port, ID width IDW+1
//   busy                any burst outstanding or any channel FSM not idle
//
// Build option: MEM_ARB_FIXED_PRIO_EN -- when defined, m0 always wins
// simultaneous requests and the round-robin state is removed.
module axi_mem_arbiter #(
  parameter int IDW    = 6,
  parameter int AW     = 32,
  parameter int DW     = 64,
  parameter int MAXOUT = 8
) (
  input  logic clock,
  input  logic reset_n,
  // master 0
  input  logic m0_axi_awvalid, output logic m0_axi_awready, input logic [AW-1:0] m0_axi_awaddr,
  input  logic [IDW-1:0] m0_axi_awid, input logic [7:0] m0_axi_awlen, input logic [2:0] m0_axi_awsize,
  input  logic [1:0] m0_axi_awburst, input logic m0_axi_awlock, input logic [3:0] m0_axi_awcache,
  input  logic [2:0] m0_axi_awprot, input logic [3:0] m0_axi_awqos,
  input  logic m0_axi_wvalid, output logic m0_axi_wready, input logic [DW-1:0] m0_axi_wdata,
  input  logic [DW/8-1:0] m0_axi_wstrb, input logic m0_axi_wlast,
  output logic m0_axi_bvalid, input logic m0_axi_bready, output logic [IDW-1:0] m0_axi_bid,
  output logic [1:0] m0_axi_bresp,
  input  logic m0_axi_arvalid, output logic m0_axi_arready, input logic [AW-1:0] m0_axi_araddr,
  input  logic [IDW-1:0] m0_axi_arid, input logic [7:0] m0_axi_arlen, input logic [2:0] m0_axi_arsize,
  input  logic [1:0] m0_axi_arburst, input logic m0_axi_arlock, input logic [3:0] m0_axi_arcache,
  input  logic [2:0] m0_axi_arprot, input logic [3:0] m0_axi_arqos,
  output logic m0_axi_rvalid, input logic m0_axi_rready, output logic [IDW-1:0] m0_axi_rid,
  output logic [DW-1:0] m0_axi_rdata, output logic [1:0] m0_axi_rresp, output logic m0_axi_rlast,
  // master 1
  input  logic m1_axi_awvalid, output logic m1_axi_awready, input logic [AW-1:0] m1_axi_awaddr,
  input  logic [IDW-1:0] m1_axi_awid, input logic [7:0] m1_axi_awlen, input logic [2:0] m1_axi_awsize,
  input  logic [1:0] m1_axi_awburst, input logic m1_axi_awlock, input logic [3:0] m1_axi_awcache,
  input  logic [2:0] m1_axi_awprot, input logic [3:0] m1_axi_awqos,
  input  logic m1_axi_wvalid, output logic m1_axi_wready, input logic [DW-1:0] m1_axi_wdata,
  input  logic [DW/8-1:0] m1_axi_wstrb, input logic m1_axi_wlast,
  output logic m1_axi_bvalid, input logic m1_axi_bready, output logic [IDW-1:0] m1_axi_bid,
  output logic [1:0] m1_axi_bresp,
  input  logic m1_axi_arvalid, output logic m1_axi_arready, input logic [AW-1:0] m1_axi_araddr,
  input  logic [IDW-1:0] m1_axi_arid, input logic [7:0] m1_axi_arlen, input logic [2:0] m1_axi_arsize,
  input  logic [1:0] m1_axi_arburst, input logic m1_axi_arlock, input logic [3:0] m1_axi_arcache,
  input  logic [2:0] m1_axi_arprot, input logic [3:0] m1_axi_arqos,
  output logic m1_axi_rvalid, input logic m1_axi_rready, output logic [IDW-1:0] m1_axi_rid,
  output logic [DW-1:0] m1_axi_rdata, output logic [1:0] m1_axi_rresp, output logic m1_axi_rlast,
  // shared slave
  output logic s_axi_awvalid, input logic s_axi_awready, output logic [AW-1:0] s_axi_awaddr,
  output logic [IDW:0] s_axi_awid, output logic [7:0] s_axi_awlen, output logic [2:0] s_axi_awsize,
  output logic [1:0] s_axi_awburst, output logic s_axi_awlock, output logic [3:0] s_axi_awcache,
  output logic [2:0] s_axi_awprot, output logic [3:0] s_axi_awqos,
  output logic s_axi_wvalid, input logic s_axi_wready, output logic [DW-1:0] s_axi_wdata,
  output logic [DW/8-1:0] s_axi_wstrb, output logic s_axi_wlast,
  input  logic s_axi_bvalid, output logic s_axi_bready, input logic [IDW:0] s_axi_bid,
  input  logic [1:0] s_axi_bresp,
  output logic s_axi_arvalid, input logic s_axi_arready, output logic [AW-1:0] s_axi_araddr,
  output logic [IDW:0] s_axi_arid, output logic [7:0] s_axi_arlen, output logic [2:0] s_axi_arsize,
  output logic [1:0] s_axi_arburst, output logic s_axi_arlock, output logic [3:0] s_axi_arcache,
  output logic [2:0] s_axi_arprot, output logic [3:0] s_axi_arqos,
  input  logic s_axi_rvalid, output logic s_axi_rready, input logic [IDW:0] s_axi_rid,
  input  logic [DW-1:0] s_axi_rdata, input logic [1:0] s_axi_rresp, input logic s_axi_rlast,
  output logic busy
);

  localparam int CW  = $clog2(MAXOUT + 1);
  localparam int ABW = AW + IDW + 8 + 3 + 2 + 1 + 4 + 3 + 4;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAXOUT);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA} w_state_t;
  typedef enum logic       {R_IDLE, R_ADDR} r_state_t;

  w_state_t w_state, w_state_nx;
  r_state_t r_state, r_state_nx;

  logic [ABW-1:0] m0_aw_bus, m1_aw_bus, aw_q, m0_ar_bus, m1_ar_bus, ar_q;
  logic [IDW-1:0] aw_id_q, ar_id_q;
  logic           w_gnt, r_gnt, w_win, r_win, w_take, r_take;
  logic [CW-1:0]  w_cnt, r_cnt;
  logic           w_inc, w_dec_ok, r_inc, r_dec_ok;

  assign m0_aw_bus = {m0_axi_awaddr, m0_axi_awid, m0_axi_awlen, m0_axi_awsize, m0_axi_awburst,
                      m0_axi_awlock, m0_axi_awcache, m0_axi_awprot, m0_axi_awqos};
  assign m1_aw_bus = {m1_axi_awaddr, m1_axi_awid, m1_axi_awlen, m1_axi_awsize, m1_axi_awburst,
                      m1_axi_awlock, m1_axi_awcache, m1_axi_awprot, m1_axi_awqos};
  assign m0_ar_bus = {m0_axi_araddr, m0_axi_arid, m0_axi_arlen, m0_axi_arsize, m0_axi_arburst,
                      m0_axi_arlock, m0_axi_arcache, m0_axi_arprot, m0_axi_arqos};
  assign m1_ar_bus = {m1_axi_araddr, m1_axi_arid, m1_axi_arlen, m1_axi_arsize, m1_axi_arburst,
                      m1_axi_arlock, m1_axi_arcache, m1_axi_arprot, m1_axi_arqos};

  assign {s_axi_awaddr, aw_id_q, s_axi_awlen, s_axi_awsize, s_axi_awburst,
          s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos} = aw_q;
  assign {s_axi_araddr, ar_id_q, s_axi_arlen, s_axi_arsize, s_axi_arburst,
          s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos} = ar_q;
  assign s_axi_awid = {w_gnt, aw_id_q};
  assign s_axi_arid = {r_gnt, ar_id_q};

  // Winner index (1 = m1); only meaningful when at least one master requests.
`ifdef MEM_ARB_FIXED_PRIO_EN
  assign w_win = ~m0_axi_awvalid;
  assign r_win = ~m0_axi_arvalid;
`else
  logic w_last, r_last;
  assign w_win = (m0_axi_awvalid & m1_axi_awvalid) ? ~w_last : m1_axi_awvalid;
  assign r_win = (m0_axi_arvalid & m1_axi_arvalid) ? ~r_last : m1_axi_arvalid;
`endif

  assign w_take = (w_state == W_IDLE) & (m0_axi_awvalid | m1_axi_awvalid) & (w_cnt != CNT_MAX);
  assign r_take = (r_state == R_IDLE) & (m0_axi_arvalid | m1_axi_arvalid) & (r_cnt != CNT_MAX);

  // A decrement at zero is a slave protocol error and is dropped, so it must
  // not cancel a same-cycle increment either.
  assign w_inc    = s_axi_awvalid & s_axi_awready;
  assign w_dec_ok = s_axi_bvalid & s_axi_bready & (w_cnt != '0);
  assign r_inc    = s_axi_arvalid & s_axi_arready;
  assign r_dec_ok = s_axi_rvalid & s_axi_rready & s_axi_rlast & (r_cnt != '0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_nx;
      r_state <= r_state_nx;
    end
  end

  always_comb begin
    w_state_nx = w_state;
    case (w_state)
      W_IDLE:  if (w_take) w_state_nx = W_ADDR;
      W_ADDR:  if (s_axi_awready) w_state_nx = W_DATA;
      W_DATA:  if (s_axi_wvalid & s_axi_wready & s_axi_wlast) w_state_nx = W_IDLE;
      default: w_state_nx = W_IDLE;
    endcase
    r_state_nx = r_state;
    if (r_state == R_IDLE) begin
      if (r_take) r_state_nx = R_ADDR;
    end else if (s_axi_arready) begin
      r_state_nx = R_IDLE;
    end
  end

  always_comb begin
    m0_axi_awready = w_take & ~w_win;
    m1_axi_awready = w_take & w_win;
    m0_axi_arready = r_take & ~r_win;
    m1_axi_arready = r_take & r_win;
    s_axi_awvalid  = (w_state == W_ADDR);
    s_axi_arvalid  = (r_state == R_ADDR);
    s_axi_wvalid   = 1'b0;
    s_axi_wdata    = '0;
    s_axi_wstrb    = '0;
    s_axi_wlast    = 1'b0;
    m0_axi_wready  = 1'b0;
    m1_axi_wready  = 1'b0;
    if (w_state == W_DATA) begin
      if (w_gnt) begin
        s_axi_wvalid  = m1_axi_wvalid;
        s_axi_wdata   = m1_axi_wdata;
        s_axi_wstrb   = m1_axi_wstrb;
        s_axi_wlast   = m1_axi_wlast;
        m1_axi_wready = s_axi_wready;
      end else begin
        s_axi_wvalid  = m0_axi_wvalid;
        s_axi_wdata   = m0_axi_wdata;
        s_axi_wstrb   = m0_axi_wstrb;
        s_axi_wlast   = m0_axi_wlast;
        m0_axi_wready = s_axi_wready;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      aw_q  <= '0;
      ar_q  <= '0;
      w_gnt <= 1'b0;
      r_gnt <= 1'b0;
      w_cnt <= '0;
      r_cnt <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      w_last <= 1'b1;
      r_last <= 1'b1;
`endif
    end else begin
      if (w_take) begin
        aw_q  <= w_win ? m1_aw_bus : m0_aw_bus;
        w_gnt <= w_win;
`ifndef MEM_ARB_FIXED_PRIO_EN
        w_last <= w_win;
`endif
      end
      if (r_take) begin
        ar_q  <= r_win ? m1_ar_bus : m0_ar_bus;
        r_gnt <= r_win;
`ifndef MEM_ARB_FIXED_PRIO_EN
        r_last <= r_win;
`endif
      end
      if (w_inc & ~w_dec_ok & (w_cnt != CNT_MAX)) w_cnt <= w_cnt + CW'(1);
      else if (~w_inc & w_dec_ok)                 w_cnt <= w_cnt - CW'(1);
      if (r_inc & ~r_dec_ok & (r_cnt != CNT_MAX)) r_cnt <= r_cnt + CW'(1);
      else if (~r_inc & r_dec_ok)                 r_cnt <= r_cnt - CW'(1);
    end
  end

  // B and R are routed on the grant tag in the top ID bit.
  assign m0_axi_bvalid = s_axi_bvalid & ~s_axi_bid[IDW];
  assign m1_axi_bvalid = s_axi_bvalid &  s_axi_bid[IDW];
  assign m0_axi_bid    = s_axi_bid[IDW-1:0];
  assign m1_axi_bid    = s_axi_bid[IDW-1:0];
  assign m0_axi_bresp  = s_axi_bresp;
  assign m1_axi_bresp  = s_axi_bresp;
  assign s_axi_bready  = s_axi_bid[IDW] ? m1_axi_bready : m0_axi_bready;

  assign m0_axi_rvalid = s_axi_rvalid & ~s_axi_rid[IDW];
  assign m1_axi_rvalid = s_axi_rvalid &  s_axi_rid[IDW];
  assign m0_axi_rid    = s_axi_rid[IDW-1:0];
  assign m1_axi_rid    = s_axi_rid[IDW-1:0];
  assign m0_axi_rdata  = s_axi_rdata;
  assign m1_axi_rdata  = s_axi_rdata;
  assign m0_axi_rresp  = s_axi_rresp;
  assign m1_axi_rresp  = s_axi_rresp;
  assign m0_axi_rlast  = s_axi_rlast;
  assign m1_axi_rlast  = s_axi_rlast;
  assign s_axi_rready  = s_axi_rid[IDW] ? m1_axi_rready : m0_axi_rready;

  assign busy = (w_cnt != '0) | (r_cnt != '0) | (w_state != W_IDLE) | (r_state != R_IDLE);

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed self-checking bench for axi_mem_arbiter (MAXOUT=8, IDW=6).
module tb_axi_mem_arbiter;
  logic clock, reset_n, busy;
  // master 0
  logic m0_axi_awvalid, m0_axi_awready, m0_axi_awlock;
  logic [31:0] m0_axi_awaddr, m0_axi_araddr;
  logic [5:0]  m0_axi_awid, m0_axi_arid, m0_axi_bid, m0_axi_rid;
  logic [7:0]  m0_axi_awlen, m0_axi_arlen, m0_axi_wstrb;
  logic [2:0]  m0_axi_awsize, m0_axi_awprot, m0_axi_arsize, m0_axi_arprot;
  logic [1:0]  m0_axi_awburst, m0_axi_arburst, m0_axi_bresp, m0_axi_rresp;
  logic [3:0]  m0_axi_awcache, m0_axi_awqos, m0_axi_arcache, m0_axi_arqos;
  logic m0_axi_wvalid, m0_axi_wready, m0_axi_wlast, m0_axi_bvalid, m0_axi_bready;
  logic [63:0] m0_axi_wdata, m0_axi_rdata;
  logic m0_axi_arvalid, m0_axi_arready, m0_axi_arlock, m0_axi_rvalid, m0_axi_rready, m0_axi_rlast;
  // master 1
  logic m1_axi_awvalid, m1_axi_awready, m1_axi_awlock;
  logic [31:0] m1_axi_awaddr, m1_axi_araddr;
  logic [5:0]  m1_axi_awid, m1_axi_arid, m1_axi_bid, m1_axi_rid;
  logic [7:0]  m1_axi_awlen, m1_axi_arlen, m1_axi_wstrb;
  logic [2:0]  m1_axi_awsize, m1_axi_awprot, m1_axi_arsize, m1_axi_arprot;
  logic [1:0]  m1_axi_awburst, m1_axi_arburst, m1_axi_bresp, m1_axi_rresp;
  logic [3:0]  m1_axi_awcache, m1_axi_awqos, m1_axi_arcache, m1_axi_arqos;
  logic m1_axi_wvalid, m1_axi_wready, m1_axi_wlast, m1_axi_bvalid, m1_axi_bready;
  logic [63:0] m1_axi_wdata, m1_axi_rdata;
  logic m1_axi_arvalid, m1_axi_arready, m1_axi_arlock, m1_axi_rvalid, m1_axi_rready, m1_axi_rlast;
  // slave
  logic s_axi_awvalid, s_axi_awready, s_axi_awlock;
  logic [31:0] s_axi_awaddr, s_axi_araddr;
  logic [6:0]  s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [7:0]  s_axi_awlen, s_axi_arlen, s_axi_wstrb;
  logic [2:0]  s_axi_awsize, s_axi_awprot, s_axi_arsize, s_axi_arprot;
  logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic [3:0]  s_axi_awcache, s_axi_awqos, s_axi_arcache, s_axi_arqos;
  logic s_axi_wvalid, s_axi_wready, s_axi_wlast, s_axi_bvalid, s_axi_bready;
  logic [63:0] s_axi_wdata, s_axi_rdata;
  logic s_axi_arvalid, s_axi_arready, s_axi_arlock, s_axi_rvalid, s_axi_rready, s_axi_rlast;

  int n_cmp = 0;
  int n_err = 0;

  axi_mem_arbiter #(.IDW(6), .AW(32), .DW(64), .MAXOUT(8)) dut (
    .clock(clock), .reset_n(reset_n), .busy(busy),
    .m0_axi_awvalid(m0_axi_awvalid), .m0_axi_awready(m0_axi_awready), .m0_axi_awaddr(m0_axi_awaddr),
    .m0_axi_awid(m0_axi_awid), .m0_axi_awlen(m0_axi_awlen), .m0_axi_awsize(m0_axi_awsize),
    .m0_axi_awburst(m0_axi_awburst), .m0_axi_awlock(m0_axi_awlock), .m0_axi_awcache(m0_axi_awcache),
    .m0_axi_awprot(m0_axi_awprot), .m0_axi_awqos(m0_axi_awqos),
    .m0_axi_wvalid(m0_axi_wvalid), .m0_axi_wready(m0_axi_wready), .m0_axi_wdata(m0_axi_wdata),
    .m0_axi_wstrb(m0_axi_wstrb), .m0_axi_wlast(m0_axi_wlast),
    .m0_axi_bvalid(m0_axi_bvalid), .m0_axi_bready(m0_axi_bready), .m0_axi_bid(m0_axi_bid),
    .m0_axi_bresp(m0_axi_bresp),
    .m0_axi_arvalid(m0_axi_arvalid), .m0_axi_arready(m0_axi_arready), .m0_axi_araddr(m0_axi_araddr),
    .m0_axi_arid(m0_axi_arid), .m0_axi_arlen(m0_axi_arlen), .m0_axi_arsize(m0_axi_arsize),
    .m0_axi_arburst(m0_axi_arburst), .m0_axi_arlock(m0_axi_arlock), .m0_axi_arcache(m0_axi_arcache),
    .m0_axi_arprot(m0_axi_arprot), .m0_axi_arqos(m0_axi_arqos),
    .m0_axi_rvalid(m0_axi_rvalid), .m0_axi_rready(m0_axi_rready), .m0_axi_rid(m0_axi_rid),
    .m0_axi_rdata(m0_axi_rdata), .m0_axi_rresp(m0_axi_rresp), .m0_axi_rlast(m0_axi_rlast),
    .m1_axi_awvalid(m1_axi_awvalid), .m1_axi_awready(m1_axi_awready), .m1_axi_awaddr(m1_axi_awaddr),
    .m1_axi_awid(m1_axi_awid), .m1_axi_awlen(m1_axi_awlen), .m1_axi_awsize(m1_axi_awsize),
    .m1_axi_awburst(m1_axi_awburst), .m1_axi_awlock(m1_axi_awlock), .m1_axi_awcache(m1_axi_awcache),
    .m1_axi_awprot(m1_axi_awprot), .m1_axi_awqos(m1_axi_awqos),
    .m1_axi_wvalid(m1_axi_wvalid), .m1_axi_wready(m1_axi_wready), .m1_axi_wdata(m1_axi_wdata),
    .m1_axi_wstrb(m1_axi_wstrb), .m1_axi_wlast(m1_axi_wlast),
    .m1_axi_bvalid(m1_axi_bvalid), .m1_axi_bready(m1_axi_bready), .m1_axi_bid(m1_axi_bid),
    .m1_axi_bresp(m1_axi_bresp),
    .m1_axi_arvalid(m1_axi_arvalid), .m1_axi_arready(m1_axi_arready), .m1_axi_araddr(m1_axi_araddr),
    .m1_axi_arid(m1_axi_arid), .m1_axi_arlen(m1_axi_arlen), .m1_axi_arsize(m1_axi_arsize),
    .m1_axi_arburst(m1_axi_arburst), .m1_axi_arlock(m1_axi_arlock), .m1_axi_arcache(m1_axi_arcache),
    .m1_axi_arprot(m1_axi_arprot), .m1_axi_arqos(m1_axi_arqos),
    .m1_axi_rvalid(m1_axi_rvalid), .m1_axi_rready(m1_axi_rready), .m1_axi_rid(m1_axi_rid),
    .m1_axi_rdata(m1_axi_rdata), .m1_axi_rresp(m1_axi_rresp), .m1_axi_rlast(m1_axi_rlast),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awid(s_axi_awid), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock), .s_axi_awcache(s_axi_awcache),
    .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bid(s_axi_bid),
    .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock), .s_axi_arcache(s_axi_arcache),
    .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rid(s_axi_rid),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic init_inputs();
    reset_n = 1'b0;
    m0_axi_awvalid = 0; m0_axi_awaddr = '0; m0_axi_awid = '0; m0_axi_awlen = '0; m0_axi_awsize = 3'd3;
    m0_axi_awburst = 2'b01; m0_axi_awlock = 0; m0_axi_awcache = '0; m0_axi_awprot = '0; m0_axi_awqos = '0;
    m0_axi_wvalid = 0; m0_axi_wdata = '0; m0_axi_wstrb = 8'hFF; m0_axi_wlast = 0; m0_axi_bready = 0;
    m0_axi_arvalid = 0; m0_axi_araddr = '0; m0_axi_arid = '0; m0_axi_arlen = '0; m0_axi_arsize = 3'd3;
    m0_axi_arburst = 2'b01; m0_axi_arlock = 0; m0_axi_arcache = '0; m0_axi_arprot = '0; m0_axi_arqos = '0;
    m0_axi_rready = 0;
    m1_axi_awvalid = 0; m1_axi_awaddr = '0; m1_axi_awid = '0; m1_axi_awlen = '0; m1_axi_awsize = 3'd3;
    m1_axi_awburst = 2'b01; m1_axi_awlock = 0; m1_axi_awcache = '0; m1_axi_awprot = '0; m1_axi_awqos = '0;
    m1_axi_wvalid = 0; m1_axi_wdata = '0; m1_axi_wstrb = 8'hFF; m1_axi_wlast = 0; m1_axi_bready = 0;
    m1_axi_arvalid = 0; m1_axi_araddr = '0; m1_axi_arid = '0; m1_axi_arlen = '0; m1_axi_arsize = 3'd3;
    m1_axi_arburst = 2'b01; m1_axi_arlock = 0; m1_axi_arcache = '0; m1_axi_arprot = '0; m1_axi_arqos = '0;
    m1_axi_rready = 0;
    s_axi_awready = 0; s_axi_wready = 0; s_axi_bvalid = 0; s_axi_bid = '0; s_axi_bresp = '0;
    s_axi_arready = 0; s_axi_rvalid = 0; s_axi_rid = '0; s_axi_rdata = '0; s_axi_rresp = '0; s_axi_rlast = 0;
  endtask

  // Stimulus only: single-beat m0 write with immediate slave acceptance, no B.
  task automatic do_write(input logic [31:0] addr);
    @(negedge clock);
    m0_axi_awvalid = 1; m0_axi_awaddr = addr; m0_axi_awid = 6'h00; m0_axi_awlen = 8'd0;
    @(negedge clock);
    m0_axi_awvalid = 0; s_axi_awready = 1;
    @(negedge clock);
    s_axi_awready = 0; m0_axi_wvalid = 1; m0_axi_wlast = 1; s_axi_wready = 1;
    @(negedge clock);
    m0_axi_wvalid = 0; m0_axi_wlast = 0; s_axi_wready = 0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if ({s_axi_awvalid, s_axi_arvalid, s_axi_wvalid} !== 3'b000) begin n_err++; $display("FAIL rst_s_valid got=%b exp=000", {s_axi_awvalid, s_axi_arvalid, s_axi_wvalid}); end
    n_cmp++; if ({m0_axi_awready, m1_axi_awready, m0_axi_arready, m1_axi_arready, m0_axi_wready, m1_axi_wready} !== 6'b0) begin n_err++; $display("FAIL rst_m_ready got=%b exp=0", {m0_axi_awready, m1_axi_awready, m0_axi_arready, m1_axi_arready, m0_axi_wready, m1_axi_wready}); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_cmp++; if ({s_axi_awaddr, s_axi_awid, s_axi_araddr, s_axi_arid, s_axi_wdata} !== '0) begin n_err++; $display("FAIL rst_s_fields got=%h exp=0", {s_axi_awaddr, s_axi_awid, s_axi_araddr, s_axi_arid}); end
    n_cmp++; if ({dut.w_cnt, dut.r_cnt} !== 8'h00) begin n_err++; $display("FAIL rst_cnt got=%h exp=00", {dut.w_cnt, dut.r_cnt}); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_single_write();
    @(negedge clock);
    m0_axi_awvalid = 1; m0_axi_awaddr = 32'h1000_0000; m0_axi_awid = 6'h05; m0_axi_awlen = 8'd3;
    #1;
    n_cmp++; if ({m0_axi_awready, m1_axi_awready, s_axi_awvalid} !== 3'b100) begin n_err++; $display("FAIL sw_grant got=%b exp=100", {m0_axi_awready, m1_axi_awready, s_axi_awvalid}); end
    @(negedge clock);
    m0_axi_awvalid = 0;
    #1;
    n_cmp++; if (s_axi_awvalid !== 1'b1) begin n_err++; $display("FAIL sw_awvalid got=%b exp=1", s_axi_awvalid); end
    n_cmp++; if ({s_axi_awid, s_axi_awaddr, s_axi_awlen} !== {7'h05, 32'h1000_0000, 8'd3}) begin n_err++; $display("FAIL sw_aw_fields got=%h exp=%h", {s_axi_awid, s_axi_awaddr, s_axi_awlen}, {7'h05, 32'h1000_0000, 8'd3}); end
    s_axi_awready = 1;
    @(negedge clock);
    s_axi_awready = 0;
    for (int i = 0; i < 4; i++) begin
      m0_axi_wvalid = 1; m0_axi_wdata = 64'hA5A5_0000_0000_0000 + 64'(i); m0_axi_wlast = (i == 3); s_axi_wready = 1;
      m1_axi_wvalid = 0;
      #1;
      n_cmp++; if ({s_axi_wvalid, m0_axi_wready, m1_axi_wready, s_axi_wlast, s_axi_awvalid} !== {3'b110, (i == 3), 1'b0}) begin n_err++; $display("FAIL sw_beat%0d_ctl got=%b exp=%b", i, {s_axi_wvalid, m0_axi_wready, m1_axi_wready, s_axi_wlast, s_axi_awvalid}, {3'b110, (i == 3), 1'b0}); end
      n_cmp++; if (s_axi_wdata !== 64'hA5A5_0000_0000_0000 + 64'(i)) begin n_err++; $display("FAIL sw_beat%0d_data got=%h exp=%h", i, s_axi_wdata, 64'hA5A5_0000_0000_0000 + 64'(i)); end
      @(negedge clock);
    end
    m0_axi_wvalid = 0; m0_axi_wlast = 0; s_axi_wready = 0;
    #1;
    n_cmp++; if ({s_axi_wvalid, dut.w_cnt} !== {1'b0, 4'd1}) begin n_err++; $display("FAIL sw_after_w got=%h exp=01", {s_axi_wvalid, dut.w_cnt}); end
    s_axi_bvalid = 1; s_axi_bid = 7'h05; s_axi_bresp = 2'b00; m0_axi_bready = 1;
    #1;
    n_cmp++; if ({m0_axi_bvalid, m1_axi_bvalid, s_axi_bready, m0_axi_bid} !== {3'b101, 6'h05}) begin n_err++; $display("FAIL sw_b_route got=%h exp=%h", {m0_axi_bvalid, m1_axi_bvalid, s_axi_bready, m0_axi_bid}, {3'b101, 6'h05}); end
    @(negedge clock);
    s_axi_bvalid = 0; m0_axi_bready = 0;
    #1;
    n_cmp++; if ({busy, dut.w_cnt} !== 5'd0) begin n_err++; $display("FAIL sw_done got=%h exp=0", {busy, dut.w_cnt}); end
    // Stray B with nothing outstanding must not wrap the counter.
    s_axi_bvalid = 1; m0_axi_bready = 1;
    @(negedge clock);
    s_axi_bvalid = 0; m0_axi_bready = 0;
    #1;
    n_cmp++; if (dut.w_cnt !== 4'd0) begin n_err++; $display("FAIL sw_no_underflow got=%0d exp=0", dut.w_cnt); end
  endtask

  task automatic test_w_before_aw();
    @(negedge clock);
    m0_axi_awvalid = 1; m0_axi_awaddr = 32'h1000_0100; m0_axi_awid = 6'h01; m0_axi_awlen = 8'd1;
    #1;
    n_cmp++; if (m0_axi_awready !== 1'b1) begin n_err++; $display("FAIL wb_m0_grant got=%b exp=1", m0_axi_awready); end
    @(negedge clock);
    m0_axi_awvalid = 0; s_axi_awready = 1;
    m1_axi_awvalid = 1; m1_axi_awaddr = 32'h2000_0000; m1_axi_awid = 6'h2A; m1_axi_awlen = 8'd0;
    m1_axi_wvalid = 1; m1_axi_wdata = 64'hD1D1_D1D1_D1D1_D1D1; m1_axi_wlast = 1;
    #1;
    n_cmp++; if ({m1_axi_awready, m1_axi_wready} !== 2'b00) begin n_err++; $display("FAIL wb_m1_in_addr got=%b exp=00", {m1_axi_awready, m1_axi_wready}); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      s_axi_awready = 0;
      m0_axi_wvalid = 1; m0_axi_wdata = 64'hB0B0_0000_0000_0000 + 64'(i); m0_axi_wlast = (i == 1); s_axi_wready = 1;
      #1;
      n_cmp++; if ({m0_axi_wready, m1_axi_wready, m1_axi_awready} !== 3'b100) begin n_err++; $display("FAIL wb_beat%0d_ready got=%b exp=100", i, {m0_axi_wready, m1_axi_wready, m1_axi_awready}); end
      n_cmp++; if (s_axi_wdata !== 64'hB0B0_0000_0000_0000 + 64'(i)) begin n_err++; $display("FAIL wb_beat%0d_data got=%h exp=%h", i, s_axi_wdata, 64'hB0B0_0000_0000_0000 + 64'(i)); end
    end
    @(negedge clock);
    m0_axi_wvalid = 0; m0_axi_wlast = 0;
    #1;
    n_cmp++; if ({m1_axi_awready, m1_axi_wready, s_axi_wvalid} !== 3'b100) begin n_err++; $display("FAIL wb_m1_grant got=%b exp=100", {m1_axi_awready, m1_axi_wready, s_axi_wvalid}); end
    @(negedge clock);
    m1_axi_awvalid = 0;
    #1;
    n_cmp++; if ({s_axi_awvalid, s_axi_awid, m1_axi_wready} !== {1'b1, 7'h6A, 1'b0}) begin n_err++; $display("FAIL wb_m1_aw got=%h exp=%h", {s_axi_awvalid, s_axi_awid, m1_axi_wready}, {1'b1, 7'h6A, 1'b0}); end
    s_axi_awready = 1;
    @(negedge clock);
    s_axi_awready = 0;
    #1;
    n_cmp++; if ({m1_axi_wready, m0_axi_wready, s_axi_wlast} !== 3'b101 || s_axi_wdata !== 64'hD1D1_D1D1_D1D1_D1D1) begin n_err++; $display("FAIL wb_m1_beat got=%b/%h exp=101/d1d1d1d1d1d1d1d1", {m1_axi_wready, m0_axi_wready, s_axi_wlast}, s_axi_wdata); end
    @(negedge clock);
    m1_axi_wvalid = 0; m1_axi_wlast = 0; s_axi_wready = 0;
  endtask

  task automatic test_rr_read();
    int seq[8];
    int g0, g1, e;
    logic [6:0] exp_id;
`ifdef MEM_ARB_FIXED_PRIO_EN
    seq = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    seq = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    g0 = 0; g1 = 0;
    m0_axi_arid = 6'h11; m0_axi_araddr = 32'h3000_0000;
    m1_axi_arid = 6'h22; m1_axi_araddr = 32'h4000_0000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      s_axi_arready = 0;
      m0_axi_arvalid = (g0 < 4); m1_axi_arvalid = (g1 < 4);
      #1;
      e = seq[k];
      n_cmp++; if ({m0_axi_arready, m1_axi_arready} !== ((e == 0) ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL rr_grant%0d got=%b exp=%b", k, {m0_axi_arready, m1_axi_arready}, (e == 0) ? 2'b10 : 2'b01); end
      if (e == 0) g0++; else g1++;
      @(negedge clock);
      m0_axi_arvalid = (g0 < 4); m1_axi_arvalid = (g1 < 4);
      exp_id = (e == 0) ? 7'h11 : 7'h62;
      #1;
      n_cmp++; if ({s_axi_arvalid, s_axi_arid} !== {1'b1, exp_id}) begin n_err++; $display("FAIL rr_arid%0d got=%h exp=%h", k, {s_axi_arvalid, s_axi_arid}, {1'b1, exp_id}); end
      s_axi_arready = 1;
    end
    @(negedge clock);
    s_axi_arready = 0; m0_axi_arvalid = 0; m1_axi_arvalid = 0;
  endtask

  task automatic test_maxout_read();
    logic leaked, got;
    #1;
    n_cmp++; if (dut.r_cnt !== 4'd8) begin n_err++; $display("FAIL mo_cnt_full got=%0d exp=8", dut.r_cnt); end
    leaked = 0;
    m0_axi_arvalid = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      #1;
      if (m0_axi_arready !== 1'b0 || s_axi_arvalid !== 1'b0) leaked = 1;
    end
    n_cmp++; if (leaked !== 1'b0) begin n_err++; $display("FAIL mo_blocked got=granted exp=blocked"); end
    s_axi_rvalid = 1; s_axi_rid = 7'h11; s_axi_rlast = 1; s_axi_rdata = 64'h1234; m0_axi_rready = 1;
    #1;
    n_cmp++; if ({m0_axi_rvalid, m1_axi_rvalid, s_axi_rready, m0_axi_rid} !== {3'b101, 6'h11}) begin n_err++; $display("FAIL mo_r_route got=%h exp=%h", {m0_axi_rvalid, m1_axi_rvalid, s_axi_rready, m0_axi_rid}, {3'b101, 6'h11}); end
    @(negedge clock);
    s_axi_rvalid = 0; s_axi_rlast = 0; m0_axi_rready = 0;
    got = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (m0_axi_arready === 1'b1) begin got = 1; break; end
      @(negedge clock);
    end
    n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL mo_regrant got=0 exp=1"); end
    @(negedge clock);
    m0_axi_arvalid = 0; s_axi_arready = 1;
    @(negedge clock);
    s_axi_arready = 0;
  endtask

  task automatic test_simul_inc_dec();
    do_write(32'h5000_0000);
    do_write(32'h5000_0040);
    do_write(32'h5000_0080);
    #1;
    n_cmp++; if (dut.w_cnt !== 4'd5) begin n_err++; $display("FAIL sim_cnt_pre got=%0d exp=5", dut.w_cnt); end
    @(negedge clock);
    m0_axi_awvalid = 1; m0_axi_awaddr = 32'h5000_00C0;
    @(negedge clock);
    m0_axi_awvalid = 0; s_axi_awready = 1;
    s_axi_bvalid = 1; s_axi_bid = 7'h00; m0_axi_bready = 1;
    @(negedge clock);
    s_axi_awready = 0; s_axi_bvalid = 0; m0_axi_bready = 0;
    #1;
    n_cmp++; if (dut.w_cnt !== 4'd5) begin n_err++; $display("FAIL sim_cnt_post got=%0d exp=5", dut.w_cnt); end
    m0_axi_wvalid = 1; m0_axi_wlast = 1; s_axi_wready = 1;
    @(negedge clock);
    m0_axi_wvalid = 0; m0_axi_wlast = 0; s_axi_wready = 0;
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clock);
    m0_axi_awvalid = 1; m0_axi_awaddr = 32'h3000_0040; m0_axi_awid = 6'h07; m0_axi_awlen = 8'd3;
    @(negedge clock);
    m0_axi_awvalid = 0; s_axi_awready = 1;
    @(negedge clock);
    s_axi_awready = 0; m0_axi_wvalid = 1; m0_axi_wdata = 64'h1; s_axi_wready = 1;
    @(negedge clock);
    m0_axi_wdata = 64'h2; reset_n = 0;
    @(negedge clock);
    reset_n = 1; m0_axi_wvalid = 0; s_axi_wready = 0;
    #1;
    n_cmp++; if ({s_axi_awvalid, s_axi_wvalid, s_axi_arvalid, m0_axi_awready, m0_axi_wready, m0_axi_arready, s_axi_bready, s_axi_rready} !== 8'h00) begin n_err++; $display("FAIL rm_handshake got=%b exp=0", {s_axi_awvalid, s_axi_wvalid, s_axi_arvalid, m0_axi_awready, m0_axi_wready, m0_axi_arready, s_axi_bready, s_axi_rready}); end
    n_cmp++; if ({busy, dut.w_cnt, dut.r_cnt} !== 9'd0) begin n_err++; $display("FAIL rm_busy_cnt got=%h exp=0", {busy, dut.w_cnt, dut.r_cnt}); end
    n_cmp++; if ({s_axi_awaddr, s_axi_awid} !== '0) begin n_err++; $display("FAIL rm_aw_fields got=%h exp=0", {s_axi_awaddr, s_axi_awid}); end
  endtask

  initial begin
    init_inputs();
    repeat (3) @(negedge clock);
    test_reset();
    test_single_write();
    test_w_before_aw();
    test_rr_read();
    test_maxout_read();
    test_simul_inc_dec();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
